// File: rtl/contador_pkg.sv
// Shared definitions for the timer digit stages: FSM state encoding,
// direction constants and the clamp/terminal helpers.
package contador_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Terminal value is the last state in the counting direction.
   function automatic logic is_terminal_val(input int unsigned value,
                                            input logic        up,
                                            input int unsigned modulus);
      return (up == DIR_UP) ? (value == modulus - 1) : (value == 0);
   endfunction

   function automatic int unsigned clamp_val(input int unsigned value,
                                             input int unsigned modulus);
      return (value > modulus - 1) ? modulus - 1 : value;
   endfunction

endpackage

// File: rtl/contador_modn_step.sv
// Combinational next-value generator for a modulo-N up/down counter,
// including the wrap at either end of the range.
module contador_modn_step
   import contador_pkg::*;
#(
   parameter int unsigned MODULUS = 10,
   parameter int unsigned WIDTH   = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   output logic [WIDTH-1:0] next_value,
   output logic             is_terminal
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

   always_comb begin
      is_terminal = is_terminal_val(32'(count), up, MODULUS);
      if (up == DIR_DOWN) begin
         next_value = is_terminal ? MAX_V : count - 1'b1;
      end else begin
         next_value = is_terminal ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/contador_modn.sv
// Parametrised modulo-N loadable up/down timer digit with wrap or one-shot mode.
// Optional registered done_pulse output when CONTADOR_MODN_DONE_PULSE_EN is defined.
module contador_modn
   import contador_pkg::*;
#(
   parameter int unsigned MODULUS = 10,
   parameter int unsigned WIDTH   = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic             oneshot,
   output logic [WIDTH-1:0] count,
   output logic             count_end,
`ifdef CONTADOR_MODN_DONE_PULSE_EN
   output logic             done_pulse,
`endif
   output logic             done
);

   if (MODULUS < 2 || (64'(1) << WIDTH) < 64'(MODULUS)) begin : g_bad_params
      $fatal(1, "contador_modn: MODULUS must be >= 2 and fit in WIDTH bits");
   end

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0] MAX_W1 = (WIDTH + 1)'(MODULUS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] step_next;
   logic             step_term;
   logic             run_step;
`ifdef CONTADOR_MODN_DONE_PULSE_EN
   logic             done_pulse_q, done_pulse_d;
`endif

   contador_modn_step #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_step (
      .count       (count_q),
      .up          (up),
      .next_value  (step_next),
      .is_terminal (step_term)
   );

   assign load_val = ({1'b0, data} > MAX_W1) ? MAX_W1[WIDTH-1:0] : data;
   assign run_step = en && (state_q == ST_RUN);

   always_comb begin
      count_d = count_q;
      state_d = state_q;
      if (load) begin
         count_d = load_val;
         state_d = ST_RUN;
      end else if (run_step) begin
         if (step_term && oneshot) begin
            state_d = ST_DONE;
         end else begin
            count_d = step_next;
         end
      end
      done_d = (state_d == ST_DONE);
`ifdef CONTADOR_MODN_DONE_PULSE_EN
      done_pulse_d = (state_q == ST_RUN) && (state_d == ST_DONE);
`endif
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count_q      <= '0;
         state_q      <= ST_RUN;
         done_q       <= 1'b0;
`ifdef CONTADOR_MODN_DONE_PULSE_EN
         done_pulse_q <= 1'b0;
`endif
      end else begin
         count_q      <= count_d;
         state_q      <= state_d;
         done_q       <= done_d;
`ifdef CONTADOR_MODN_DONE_PULSE_EN
         done_pulse_q <= done_pulse_d;
`endif
      end
   end

   // Combinational so a chained stage advances on the same edge.
   assign count_end = run_step && step_term;
   assign count     = count_q;
   assign done      = done_q;
`ifdef CONTADOR_MODN_DONE_PULSE_EN
   assign done_pulse = done_pulse_q;
`endif

endmodule

// File: tb/tb_contador_modn.sv
// Scoreboard bench for contador_modn: a units (mod 10) stage cascaded into a tens (mod 6) stage.
module tb_contador_modn;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       load = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       oneshot = 1'b0;
   logic [3:0] data = '0;
   logic [3:0] count, tens_count;
   logic       count_end, done, tens_end, tens_done;
`ifdef CONTADOR_MODN_DONE_PULSE_EN
   logic       done_pulse, tens_dp;
`endif

   typedef struct {
      string      name;
      logic [3:0] cnt;
      logic       dn;
      logic       ce;
      logic       dp;
      bit         chk_tens;
      logic [3:0] tens;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   event chk_now;

   always #5 clk = ~clk;

   contador_modn #(.MODULUS(10), .WIDTH(4)) dut (
      .clk        (clk),
      .clear      (clear),
      .data       (data),
      .load       (load),
      .en         (en),
      .up         (up),
      .oneshot    (oneshot),
      .count      (count),
      .count_end  (count_end),
`ifdef CONTADOR_MODN_DONE_PULSE_EN
      .done_pulse (done_pulse),
`endif
      .done       (done)
   );

   contador_modn #(.MODULUS(6), .WIDTH(4)) u_tens (
      .clk        (clk),
      .clear      (clear),
      .data       (4'd0),
      .load       (1'b0),
      .en         (count_end),
      .up         (1'b0),
      .oneshot    (1'b0),
      .count      (tens_count),
      .count_end  (tens_end),
`ifdef CONTADOR_MODN_DONE_PULSE_EN
      .done_pulse (tens_dp),
`endif
      .done       (tens_done)
   );

   initial begin : monitor
      forever begin
         @(posedge clk or chk_now);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            bit   bad;
            e = q.pop_front();
            bad = (count !== e.cnt) || (done !== e.dn) || (count_end !== e.ce) ||
                  (e.chk_tens && (tens_count !== e.tens));
`ifdef CONTADOR_MODN_DONE_PULSE_EN
            bad = bad || (done_pulse !== e.dp);
`endif
            checks++;
            if (bad) begin
               failures++;
               $display("FAIL %s: actual/expected count=%0d/%0d done=%0b/%0b count_end=%0b/%0b tens=%0d/%0d",
                        e.name, count, e.cnt, done, e.dn, count_end, e.ce, tens_count, e.tens);
`ifdef CONTADOR_MODN_DONE_PULSE_EN
               $display("FAIL %s: actual/expected done_pulse=%0b/%0b", e.name, done_pulse, e.dp);
`endif
            end
         end
      end
   end

   task automatic cyc(input string name, input logic ld, input logic [3:0] d,
                      input logic e_en, input logic u, input logic os,
                      input logic [3:0] xc, input logic xd, input logic xe, input logic xdp,
                      input bit ct = 1'b0, input logic [3:0] xt = 4'd0);
      @(negedge clk);
      load = ld; data = d; en = e_en; up = u; oneshot = os;
      q.push_back('{name, xc, xd, xe, xdp, ct, xt});
      @(posedge clk);
   endtask

   // Asserts clear between edges and checks outputs before any clock edge occurs.
   task automatic clear_pulse(input string name);
      @(negedge clk);
      load = 1'b0; en = 1'b0;
      #2;
      clear = 1'b1;
      q.push_back('{name, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
      -> chk_now;
      #2;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int dw[8] = '{5, 4, 3, 2, 1, 0, 9, 8};
      #2;
      q.push_back('{"reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
      -> chk_now;
      #2;
      @(negedge clk);
      clear = 1'b0;

      cyc("load5", 1, 4'd5, 0, 0, 0, 4'd5, 0, 0, 0);
      clear_pulse("clear_async");

      cyc("dw_load6", 1, 4'd6, 0, 0, 0, 4'd6, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc("dw_step", 0, 4'd0, 1, 0, 0, 4'(dw[i]), 0, (dw[i] == 0), 0);

      cyc("os_load7",   1, 4'd7, 0, 1, 1, 4'd7, 0, 0, 0);
      cyc("os_to8",     0, 4'd0, 1, 1, 1, 4'd8, 0, 0, 0);
      cyc("os_to9",     0, 4'd0, 1, 1, 1, 4'd9, 0, 1, 0);
      cyc("os_done",    0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 1);
      cyc("os_hold1",   0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 0);
      cyc("os_hold2",   0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 0);
      cyc("os_reload2", 1, 4'd2, 0, 1, 1, 4'd2, 0, 0, 0);

      cyc("clamp12",  1, 4'd12, 0, 0, 0, 4'd9, 0, 0, 0);
      cyc("clamp15",  1, 4'd15, 0, 0, 0, 4'd9, 0, 0, 0);
      cyc("load9",    1, 4'd9,  0, 0, 0, 4'd9, 0, 0, 0);
      cyc("load_en3", 1, 4'd3,  1, 0, 0, 4'd3, 0, 0, 0);
      cyc("load_en0", 1, 4'd0,  1, 0, 0, 4'd0, 0, 1, 0);

      cyc("dir_up",   0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 0);
      cyc("dir_down", 0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);

      cyc("pd_load1", 1, 4'd1, 0, 0, 1, 4'd1, 0, 0, 0);
      cyc("pd_to0",   0, 4'd0, 1, 0, 1, 4'd0, 0, 1, 0);
      cyc("pd_done",  0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 1);
      cyc("pd_hold",  0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 0);
      clear_pulse("pd_clear");

      for (int k = 1; k <= 60; k++) begin
         int u;
         int t;
         u = (10 - (k % 10)) % 10;
         t = (60 - ((k + 9) / 10)) % 6;
         cyc("cascade", 0, 4'd0, 1, 0, 0, 4'(u), 0, (u == 0), 0, 1'b1, 4'(t));
      end

      for (int i = 0; i < 5 && q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d required=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/contador_modn.md
Name: contador_modn

Overview:
- Parametrised modulo-N timer counter. Generalises the fixed mod-10 loadable down counter to any modulus and width.
- Adds up/down direction, wrap vs one-shot mode, load clamping and a cascade-ready terminal output.
- Used as a digit stage of the timer (seconds/minutes chains). Instances chain by feeding `count_end` into the next stage's `en`.

Parameters:
- MODULUS, 10, number of states; count range 0..MODULUS-1; must be >= 2.
- WIDTH, 4, width of `data`/`count`; must satisfy 2**WIDTH >= MODULUS (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- data  input  WIDTH  load value.
- load  input  1  synchronous load strobe.
- en  input  1  count enable / cascade carry-in.
- up  input  1  direction: 1 = count up, 0 = count down.
- oneshot  input  1  mode: 1 = stop at terminal, 0 = wrap.
- count  output  WIDTH  current value.
- count_end  output  1  terminal-event strobe (combinational), for cascading.
- done  output  1  one-shot completed flag (registered).

Behaviour:
- Reset: `clear`=1 asynchronously forces count=0, state=RUN, done=0. This holds until `clear` deasserts, regardless of clk, and applies mid-operation too.
- States: RUN, DONE. done = (state==DONE).
- Terminal value: count==0 when up=0; count==MODULUS-1 when up=1.
- Priority each rising edge: `load`, then `en`, then hold.
- Load:
  - count <= min(data, MODULUS-1); out-of-range data clamps to MODULUS-1.
  - state <= RUN, so done clears the next cycle.
  - Load with en=1 in the same cycle loads only; no step.
- RUN, en=1, not terminal: count steps by ±1 per `up`. Takes effect in the same edge (latency 1 cycle).
- RUN, en=1, at terminal:
  - oneshot=0: wrap (down 0->MODULUS-1, up MODULUS-1->0); stay RUN.
  - oneshot=1: count holds; state <= DONE.
- DONE: count holds; `en` ignored; only `load` or `clear` exits.
- count_end = en & (state==RUN) & terminal. It is combinational so a downstream stage steps on the same edge. It never asserts in DONE.
- Changing `up` or `oneshot` mid-count: takes effect on the next enabled edge. No glitch in count; terminal is re-evaluated for the new direction.
- en=0 and load=0: all state holds.
- Arithmetic: all in WIDTH bits. The clamp compare uses WIDTH+1 bits so MODULUS == 2**WIDTH is legal.

Optional Feature:
- Macro CONTADOR_MODN_DONE_PULSE_EN.
- Defined:
  - Extra output `done_pulse` (1 bit, registered, reset 0).
  - High for exactly one cycle on the RUN->DONE transition.
  - Not re-asserted while staying in DONE.
  - Not asserted on a wrap.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package contador_pkg holds:
  - state encoding ST_RUN=1'b0, ST_DONE=1'b1;
  - direction constants DIR_DOWN=1'b0, DIR_UP=1'b1;
  - the clamp/terminal helper functions, reused by other timer stages.
- One sub-module: contador_modn_step (combinational).
  - Inputs: count, up.
  - Outputs: next_value, is_terminal.
  - Instantiated once; keeps wrap arithmetic separate from the FSM.

Test Plan:
- Reset: MODULUS=10, count at 5, pulse clear=1 between clock edges -> count=0, done=0, count_end=0 immediately, without waiting for a clock edge.
- Down-wrap: load data=6, then up=0, oneshot=0, en=1 for 8 cycles -> count 6,5,4,3,2,1,0,9,8. count_end=1 only in the cycle count==0.
- Up one-shot:
  - Load 7, up=1, oneshot=1, en=1 -> 8, 9, then hold 9; done=1 from the next edge; count_end high one cycle only.
  - Further en has no effect.
  - Load 2 -> count=2, done=0.
- Clamp and priority:
  - load=1, data=12 -> count=9.
  - load=1, en=1, data=3 -> count=3 (not 2 or 4).
- Cascade: units (MODULUS=10) count_end drives tens (MODULUS=6) en; both down, wrap, both start at 0. First enabled edge -> tens=5, units=9. After 59 further enabled units steps -> both 0.
- With CONTADOR_MODN_DONE_PULSE_EN: one-shot down from 1 -> done_pulse high exactly one cycle when entering DONE. Assert clear mid-DONE -> done_pulse=0, done=0.
